// File: rtl/tt6581_pkg.sv
// Shared definitions for the TT6581 SPI register interface: frame layout
// constants and the frame-tracking state machine encoding.
package tt6581_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } spi_state_e;

    localparam int FRAME_LEN    = 16;               // bits per SPI frame
    localparam int ADDR_FIELD_W = 7;                // address field in the frame
    localparam int RW_BIT       = 15;               // 1 = write
    localparam int DATA_W       = 8;                // data byte width
    localparam int CMD_LEN      = FRAME_LEN - DATA_W;
    localparam int BIT_CNT_W    = $clog2(FRAME_LEN + 1);

    // Command byte helper: R/W flag position once only the first byte is in.
    function automatic logic cmd_is_write(input logic [DATA_W-1:0] cmd);
        return cmd[RW_BIT-DATA_W];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Double-register the input; reset to the line's idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/spi_regif.sv
// SPI mode-0 slave that turns 16-bit frames into register-bank write strobes
// and, when TT6581_SPI_READBACK_EN is defined, returns register contents on miso.
// Frame: [15] R/W (1 = write), [14:8] address, [7:0] data, MSB first.
module spi_regif
    import tt6581_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sclk_i,
    input  logic              cs_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [7:0]        rd_data_i
);

    logic sclk_sync_s, cs_sync_s, mosi_sync_s;
    logic sclk_d_r, cs_d_r;
    logic [1:0] sync_ok_r;
    logic armed_r;
    logic sclk_rise_s, sclk_fall_s, cs_fall_s;

    spi_state_e state_r, next_state_s;
    logic [BIT_CNT_W-1:0] bit_cnt_r;
    logic [FRAME_LEN-2:0] shift_in_r;
    logic [FRAME_LEN-1:0] frame_next_s;
    logic shift_en_s, last_cmd_s, last_data_s;

    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [7:0]        wr_data_r;
    logic              unused_s;

    sync_2ff #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk_i), .rst_n(rst_ni), .d(sclk_i), .q(sclk_sync_s));
    sync_2ff #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk_i), .rst_n(rst_ni), .d(cs_i),   .q(cs_sync_s));
    sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk_i), .rst_n(rst_ni), .d(mosi_i), .q(mosi_sync_s));

    // Edge history; armed_r only rises once cs has been seen high on real
    // (post-reset) synchronizer data, so a frame in progress at reset release is ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_d_r  <= 1'b0;
            cs_d_r    <= 1'b1;
            sync_ok_r <= 2'b00;
            armed_r   <= 1'b0;
        end else begin
            sclk_d_r  <= sclk_sync_s;
            cs_d_r    <= cs_sync_s;
            sync_ok_r <= {sync_ok_r[0], 1'b1};
            armed_r   <= armed_r | (sync_ok_r[1] & cs_sync_s);
        end
    end

    assign sclk_rise_s  = sclk_sync_s & ~sclk_d_r;
    assign sclk_fall_s  = ~sclk_sync_s & sclk_d_r;
    assign cs_fall_s    = armed_r & cs_d_r & ~cs_sync_s;
    assign frame_next_s = {shift_in_r, mosi_sync_s};

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; cs high always wins, discarding partial frames.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: if (cs_fall_s)   next_state_s = ST_CMD;
                     else             next_state_s = ST_IDLE;
            ST_CMD:  if (cs_sync_s)   next_state_s = ST_IDLE;
                     else if (last_cmd_s)  next_state_s = ST_DATA;
                     else             next_state_s = ST_CMD;
            ST_DATA: if (cs_sync_s)   next_state_s = ST_IDLE;
                     else if (last_data_s) next_state_s = ST_DONE;
                     else             next_state_s = ST_DATA;
            ST_DONE: if (cs_sync_s)   next_state_s = ST_IDLE;
                     else             next_state_s = ST_DONE;
            default:                  next_state_s = ST_IDLE;
        endcase
    end

    // FSM output decode: which sclk rising edges are accepted and which complete a phase.
    always_comb begin
        shift_en_s  = 1'b0;
        last_cmd_s  = 1'b0;
        last_data_s = 1'b0;
        case (state_r)
            ST_CMD: begin
                shift_en_s = sclk_rise_s & ~cs_sync_s;
                last_cmd_s = shift_en_s & (bit_cnt_r == BIT_CNT_W'(CMD_LEN - 1));
            end
            ST_DATA: begin
                shift_en_s  = sclk_rise_s & ~cs_sync_s;
                last_data_s = shift_en_s & (bit_cnt_r == BIT_CNT_W'(FRAME_LEN - 1));
            end
            default: begin
                shift_en_s  = 1'b0;
                last_cmd_s  = 1'b0;
                last_data_s = 1'b0;
            end
        endcase
    end

    // Bit counter and input shift register; counter clears while idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_cnt_r  <= {BIT_CNT_W{1'b0}};
            shift_in_r <= {(FRAME_LEN-1){1'b0}};
        end else if (state_r == ST_IDLE) begin
            bit_cnt_r  <= {BIT_CNT_W{1'b0}};
        end else if (shift_en_s) begin
            bit_cnt_r  <= bit_cnt_r + BIT_CNT_W'(1);
            shift_in_r <= frame_next_s[FRAME_LEN-2:0];
        end
    end

    // Write strobe: one cycle after the 16th accepted edge of a write frame;
    // address/data are held until the next strobe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
            wr_data_r <= 8'h00;
        end else begin
            wr_en_r <= 1'b0;
            if (last_data_s && frame_next_s[RW_BIT]) begin
                wr_en_r   <= 1'b1;
                wr_addr_r <= frame_next_s[DATA_W +: ADDR_W];
                wr_data_r <= frame_next_s[DATA_W-1:0];
            end
        end
    end

    assign wr_en_o   = wr_en_r;
    assign wr_addr_o = wr_addr_r;
    assign wr_data_o = wr_data_r;

`ifdef TT6581_SPI_READBACK_EN
    logic              rd_frame_r;
    logic              load_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic [7:0]        shift_out_r;
    logic              miso_r;

    // Capture the read address and frame direction when the command byte completes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_addr_r  <= {ADDR_W{1'b0}};
            rd_frame_r <= 1'b0;
            load_r     <= 1'b0;
        end else if (last_cmd_s) begin
            rd_addr_r  <= frame_next_s[ADDR_W-1:0];
            rd_frame_r <= ~cmd_is_write(frame_next_s[DATA_W-1:0]);
            load_r     <= 1'b1;
        end else begin
            load_r     <= 1'b0;
        end
    end

    // Output shifter: load register data after the command, emit MSB on each
    // sclk falling edge of a read frame's data phase, otherwise hold miso low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_out_r <= 8'h00;
            miso_r      <= 1'b0;
        end else if ((state_r != ST_DATA) || !rd_frame_r) begin
            miso_r      <= 1'b0;
        end else if (load_r) begin
            shift_out_r <= rd_data_i;
        end else if (sclk_fall_s) begin
            miso_r      <= shift_out_r[7];
            shift_out_r <= {shift_out_r[6:0], 1'b0};
        end
    end

    assign rd_addr_o = rd_addr_r;
    assign miso_o    = miso_r;
    assign unused_s  = ^frame_next_s;
`else
    // Readback not built: read frames run through the FSM and are dropped.
    assign rd_addr_o = {ADDR_W{1'b0}};
    assign miso_o    = 1'b0;
    assign unused_s  = ^{rd_data_i, sclk_fall_s, frame_next_s};
`endif

endmodule

// File: tb/tb_spi_regif.sv
// Scoreboard bench for spi_regif: expected write strobes and miso bits are
// queued when a frame is driven and compared as the DUT produces them.
module tb_spi_regif;

    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              sclk = 1'b0;
    logic              cs = 1'b1;
    logic              mosi = 1'b0;
    logic              miso;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;

    logic [7:0]  mem [32];
    logic [12:0] wr_q [$];
    logic        miso_q [$];
    logic [12:0] wr_exp;
    logic [ADDR_W-1:0] hold_addr = '0;
    logic [7:0]        hold_data = 8'h00;

    int test_cnt = 0;
    int fail_cnt = 0;

    spi_regif #(.ADDR_W(ADDR_W)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .sclk_i    (sclk),
        .cs_i      (cs),
        .mosi_i    (mosi),
        .miso_o    (miso),
        .wr_en_o   (wr_en),
        .wr_addr_o (wr_addr),
        .wr_data_o (wr_data),
        .rd_addr_o (rd_addr),
        .rd_data_i (rd_data)
    );

    always #5 clk = ~clk;

    always_comb rd_data = mem[rd_addr];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        test_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Strobe monitor: every strobe cycle must match the head of the write queue.
    always @(negedge clk) begin
        if (rst_ni && wr_en) begin
            if (wr_q.size() == 0) begin
                check("wr_unexpected", 32'd1, 32'd0);
            end else begin
                wr_exp = wr_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(wr_exp[12:8]));
                check("wr_data", 32'(wr_data), 32'(wr_exp[7:0]));
                hold_addr = wr_exp[12:8];
                hold_data = wr_exp[7:0];
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"},   32'(wr_en),   32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check({tag, "_miso"},    32'(miso),    32'd0);
    endtask

    // Queue what the frame should produce: a strobe for a complete, undisturbed
    // write frame, and per rising edge the miso level the master should see.
    task automatic expect_frame(input logic [15:0] f, input int n_edges, input bit rst_mid);
        logic [7:0] rv;
        logic       b;
        rv = mem[f[8 +: ADDR_W]];
        if (f[15] && n_edges >= 16 && !rst_mid)
            wr_q.push_back({f[8 +: ADDR_W], f[7:0]});
        for (int i = 0; i < n_edges; i++) begin
            b = 1'b0;
`ifdef TT6581_SPI_READBACK_EN
            if (!f[15] && !rst_mid && i >= 8 && i < 16) b = rv[15 - i];
`endif
            miso_q.push_back(b);
        end
    endtask

    // Drive one SPI frame with n_edges sclk cycles; rst_at >= 0 pulses reset
    // just before that (0-based) rising edge.
    task automatic xfer(input logic [15:0] f, input int n_edges, input int rst_at);
        expect_frame(f, n_edges, rst_at >= 0);
        @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < n_edges; i++) begin
            if (i == rst_at) begin
                rst_ni = 1'b0;
                @(negedge clk);
                check_reset_outputs("rst_mid");
                hold_addr = '0;
                hold_data = 8'h00;
                @(negedge clk);
                rst_ni = 1'b1;
            end
            mosi = (i < 16) ? f[15 - i] : 1'($urandom);
            repeat (4) @(negedge clk);
            if (miso_q.size() == 0) check("miso_q_empty", 32'd1, 32'd0);
            else                    check("miso", 32'(miso), 32'(miso_q.pop_front()));
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        cs   = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge clk);
        check("wr_addr_hold", 32'(wr_addr), 32'(hold_addr));
        check("wr_data_hold", 32'(wr_data), 32'(hold_data));
    endtask

    task automatic check_rd_addr(input logic [15:0] f);
`ifdef TT6581_SPI_READBACK_EN
        check("rd_addr", 32'(rd_addr), 32'(f[8 +: ADDR_W]));
`else
        check("rd_addr", 32'(rd_addr), 32'd0);
`endif
    endtask

    initial begin
        logic [15:0] f;
        for (int i = 0; i < 32; i++) mem[i] = 8'(i * 37 + 5);
        mem[4] = 8'hC3;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_ni = 1'b1;
        repeat (6) @(negedge clk);

        // Basic write.
        xfer(16'h8F5A, 16, -1);
        // Read of address 4 (0xC3 when readback is built, else miso held low).
        xfer(16'h0400, 16, -1);
        check_rd_addr(16'h0400);
        // Aborted write then a complete one.
        xfer(16'h8777, 10, -1);
        xfer(16'h8111, 16, -1);
        // Extra clocks after the frame are ignored.
        xfer(16'h8AFF, 24, -1);
        // Reset during edge 12: frame must be dropped; next one accepted.
        xfer(16'h8C3C, 16, 11);
        xfer(16'h8233, 16, -1);
        // Upper address bits beyond ADDR_W are ignored.
        xfer(16'hFF12, 16, -1);
        // Random frames.
        for (int k = 0; k < 6; k++) begin
            f = 16'($urandom);
            xfer(f, 16, -1);
            if (!f[15]) check_rd_addr(f);
        end

        repeat (10) @(negedge clk);
        check("wr_pending", 32'(wr_q.size()), 32'd0);
        check("miso_left", 32'(miso_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/spi_regif.md
SPI_REGIF -- requirements
Module: spi_regif

Interface
- REQ-001 SHALL have parameter ADDR_W, default 5: register address width used from the 7-bit frame address field; legal 1..7.
- REQ-002 SHALL have port clk_i, input, 1: system clock, the only clock.
- REQ-003 SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
- REQ-004 SHALL have port sclk_i, input, 1: SPI clock, asynchronous to clk_i.
- REQ-005 SHALL have port cs_i, input, 1: SPI chip select, active-low, asynchronous.
- REQ-006 SHALL have port mosi_i, input, 1: SPI data in, asynchronous.
- REQ-007 SHALL have port miso_o, output, 1: SPI data out.
- REQ-008 SHALL have port wr_en_o, output, 1: one-cycle register write strobe.
- REQ-009 SHALL have port wr_addr_o, output, ADDR_W: write address, valid with wr_en_o.
- REQ-010 SHALL have port wr_data_o, output, 8: write data, valid with wr_en_o.
- REQ-011 SHALL have port rd_addr_o, output, ADDR_W: read address to the core register bank.
- REQ-012 SHALL have port rd_data_i, input, 8: read data returned combinationally for rd_addr_o.

Function
- REQ-013 SHALL pass sclk_i, cs_i and mosi_i each through a 2-flop synchronizer; all edge detection uses synchronized values; clk_i SHALL be at least 4x sclk_i.
- REQ-014 SHALL implement SPI mode 0, MSB first: sample mosi on sclk rising edge, update miso on sclk falling edge.
- REQ-015 SHALL use a 16-bit frame: bit15 R/W (1 = write), bits14:8 address (low ADDR_W bits used, rest ignored), bits7:0 data.
- REQ-016 SHALL implement FSM IDLE -> CMD (rising edges 1..8) -> DATA (edges 9..16) -> DONE; IDLE -> CMD on synchronized cs falling edge.
- REQ-017 SHALL return to IDLE from any state within one clk_i cycle of synchronized cs high, discarding any partial frame without a write.
- REQ-018 SHALL ignore sclk edges in DONE; bits beyond 16 have no effect.
- REQ-019 SHALL, on a write frame, assert wr_en_o for exactly one clk_i cycle, the cycle after the 16th rising edge is detected, with wr_addr_o/wr_data_o held stable that cycle and until the next strobe.
- REQ-020 SHALL, if the 16th rising edge and cs deassertion are detected in the same clk_i cycle, discard the frame.
- REQ-021 SHALL drive rd_addr_o from the address field once CMD completes, and load rd_data_i into the output shift register in the clk_i cycle after the 8th rising edge.
- REQ-022 SHALL present rd_data_i bit7 on miso_o from the falling edge after edge 8, shifting one bit per falling edge; miso_o SHALL be 0 in IDLE, CMD, DONE and during write frames.
- REQ-023 SHALL never assert wr_en_o for read frames.

Reset
- REQ-024 SHALL, while rst_ni is low, force state IDLE, bit counter 0, synchronizers to idle levels (sclk 0, cs 1, mosi 0), miso_o 0, wr_en_o 0, wr_addr_o 0, wr_data_o 0, rd_addr_o 0.
- REQ-025 SHALL, on reset release mid-frame, wait for a fresh cs falling edge before accepting bits.

Configuration
- REQ-026 SHALL compile readback only when TT6581_SPI_READBACK_EN is defined; without it miso_o is constant 0, rd_addr_o is constant 0, rd_data_i is unused, and read frames are consumed and discarded.

Structure
- REQ-027 SHALL take the FSM state enum, frame length (16), address field width (7) and R/W bit position from shared package tt6581_pkg.
- REQ-028 SHALL instantiate sub-module sync_2ff three times for the input synchronizers.

Verification
- REQ-029 Write frame 0x8F5A (addr 0x0F, data 0x5A) -> exactly one wr_en_o pulse with wr_addr_o=0x0F and wr_data_o=0x5A.
- REQ-030 With rd_data_i=0xC3 at addr 0x04, read frame 0x0400 -> rd_addr_o=0x04, miso_o bits 1100_0011 sampled on edges 9..16, no wr_en_o.
- REQ-031 Write frame aborted with cs high after 10 edges, then full frame 0x8111 -> only one strobe, addr 0x01, data 0x11.
- REQ-032 Write frame 0x8AFF followed by 8 extra sclk cycles before cs high -> single strobe, addr 0x0A, data 0xFF.
- REQ-033 rst_ni pulsed low at edge 12 of a write frame, then frame completes -> no strobe until next complete frame.
- REQ-034 Build without TT6581_SPI_READBACK_EN, read frame 0x0400 -> miso_o stays 0, no wr_en_o.
